// File: rtl/instr_loader_if.sv
// ============================================================================
//  Module   : instr_loader_if
//  Brief    : Byte-stream, control and instruction-memory write bundle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_loader_if #(
    parameter int N  = 32,
    parameter int AW = 5
);
    logic          start;
    logic [AW:0]   word_count;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          mem_we;
    logic [N-1:0]  mem_addr;
    logic [N-1:0]  mem_wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_hold;

    modport slave (
        input  start, word_count, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
    );

    modport master (
        output start, word_count, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
    );
endinterface

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
//  Module   : instr_loader
//  Brief    : Assembles a MSB-first byte stream into words and writes them to
//             consecutive instruction-memory addresses while holding the CPU.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module instr_loader #(
    parameter int N     = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    instr_loader_if.slave bus
);
    localparam int              BPW         = N / 8;
    localparam int              BCW         = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCW-1:0]  c_last_byte = BCW'(BPW - 1);
    localparam logic [AW:0]     c_depth     = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        c_idle  = 2'd0,
        c_recv  = 2'd1,
        c_write = 2'd2,
        c_done  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BCW-1:0]  r_byte_cnt;
    logic [AW-1:0]   r_word_cnt;
    logic [AW:0]     r_count;
    logic [N-1:0]    r_shift;
    logic            r_error;

    logic            w_count_ok;
    logic            w_accept;
    logic            w_last_byte;
    logic            w_last_word;

    assign w_count_ok  = (bus.word_count != '0) && (bus.word_count <= c_depth);
    assign w_accept    = (r_state == c_recv) && bus.byte_valid;
    assign w_last_byte = (r_byte_cnt == c_last_byte);
    assign w_last_word = ({1'b0, r_word_cnt} == (r_count - (AW + 1)'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every output is a decode of registered state, so reset clears them at once.
    always_comb begin
        w_state_nxt    = r_state;
        bus.byte_ready = 1'b0;
        bus.mem_we     = 1'b0;
        bus.busy       = 1'b0;
        bus.cpu_hold   = 1'b0;
        bus.done       = 1'b0;
        case (r_state)
            c_idle: begin
                if (bus.start && w_count_ok) begin
                    w_state_nxt = c_recv;
                end
            end
            c_recv: begin
                bus.byte_ready = 1'b1;
                bus.busy       = 1'b1;
                bus.cpu_hold   = 1'b1;
                if (w_accept && w_last_byte) begin
                    w_state_nxt = c_write;
                end
            end
            c_write: begin
                bus.mem_we   = 1'b1;
                bus.busy     = 1'b1;
                bus.cpu_hold = 1'b1;
                w_state_nxt  = w_last_word ? c_done : c_recv;
            end
            c_done: begin
                bus.done     = 1'b1;
                bus.busy     = 1'b1;
                bus.cpu_hold = 1'b1;
                w_state_nxt  = c_idle;
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_count    <= '0;
            r_shift    <= '0;
            r_error    <= 1'b0;
        end else begin
            r_error <= (r_state == c_idle) && bus.start && !w_count_ok;
            case (r_state)
                c_idle: begin
                    if (bus.start && w_count_ok) begin
                        r_count    <= bus.word_count;
                        r_word_cnt <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                c_recv: begin
                    if (w_accept) begin
                        r_shift    <= (r_shift << 8) | N'(bus.byte_in);
                        r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + 1'b1;
                    end
                end
                c_write: begin
                    // The count check guarantees the final address fits; no wrap.
                    if (!w_last_word) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = {{(N - AW){1'b0}}, r_word_cnt};
    assign bus.mem_wdata = r_shift;
    assign bus.error     = r_error;

endmodule

`default_nettype wire

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer-side counterpart to the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles 32-bit instruction words, most significant byte first.
- Each assembled word is written into consecutive instruction-memory locations through a single-cycle write port, starting at word 0.
- While loading, it holds the CPU through cpu_hold so that no fetch sees a partially loaded program.

Parameters:
- N, 32, instruction/data word width (must be a multiple of 8).
- Depth, 32, number of instruction-memory words.
- AW, 5, word-address counter width (log2 Depth).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle load request; sampled only in IDLE.
- word_count  input  AW+1  number of words to load; latched on accepted start.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction-memory write enable.
- mem_addr  output  N  word address for the write (zero-extended counter).
- mem_wdata  output  N  assembled instruction word.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse after the final word is written.
- error  output  1  one-cycle pulse when start is rejected.
- cpu_hold  output  1  stall/hold request to the processor.

Behaviour:
- Reset is asynchronous and active-high. All of these go to 0: state=IDLE, byte counter, word counter, shift register, latched count, byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold.
- FSM states are IDLE, RECV, WRITE, DONE. All outputs are registered or decoded from registered state (Moore); none depend combinationally on byte_valid.
- IDLE:
  - byte_ready=0, busy=0, cpu_hold=0.
  - start=1 with 1 <= word_count <= Depth: latch word_count, clear the word counter to 0 and the byte counter to 0, go to RECV.
  - start=1 with word_count=0 or word_count>Depth: error=1 for the next cycle, remain IDLE, no write.
- RECV:
  - byte_ready=1, busy=1, cpu_hold=1.
  - A byte is accepted only on a cycle where byte_valid=1 and byte_ready=1.
  - On accept: shift_reg <= {shift_reg[N-9:0], byte_in}, and the byte counter increments.
  - On the accept that completes the word (N/8 bytes), go to WRITE. The byte counter wraps to 0.
  - Idle cycles (byte_valid=0) do not advance anything; there is no timeout.
- WRITE:
  - Lasts exactly one cycle.
  - mem_we=1, mem_addr=word counter, mem_wdata=assembled word, byte_ready=0. Any byte_valid in this cycle is not accepted.
  - Next cycle: if word counter == latched count-1, go to DONE. Otherwise increment the word counter and return to RECV.
- DONE:
  - Lasts one cycle. done=1, busy=1, cpu_hold=1, byte_ready=0. Next state is IDLE.
  - cpu_hold deasserts the cycle after done.
- Latency: mem_we asserts exactly 1 cycle after the clock edge that accepts the last byte of a word.
- Peak rate: one word per 5 cycles (4 byte cycles + 1 write cycle).
- Addresses never wrap. The count check bounds the final address to Depth-1.
- start is ignored in RECV, WRITE and DONE. It produces no error.
- mem_we is never asserted outside WRITE.
- Reset mid-load: the partial word is discarded, no write is issued, and cpu_hold drops immediately (asynchronously). Words already written remain in memory.

Test Plan:
- Reset with byte_valid=1 held -> byte_ready=0, mem_we=0, cpu_hold=0, done=0 throughout reset and in IDLE.
- start, word_count=1, bytes 00,22,18,20 back-to-back -> one write of mem_addr=0, mem_wdata=32'h00221820, 1 cycle after the 4th accept; done pulse the following cycle; cpu_hold high from the cycle after start through the done cycle.
- word_count=3 with streams 00221820, 0105302A, 003F1024 and byte_valid gaps inserted -> writes at addresses 0, 1, 2 with exactly those words; no byte is accepted during WRITE cycles; a single done pulse.
- start with word_count=0, then with 33 -> error pulse each time, no mem_we, state stays IDLE. word_count=32 -> 32 writes, last mem_addr=31.
- Assert reset after 2 bytes of word 1 in a 2-word load -> no second write; all outputs 0. A fresh load afterwards writes from address 0.
- Pulse start during RECV with a different word_count -> ignored; the original count completes; no error.
